// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_to_bin_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: digits of 8 or more lose 3 after a right shift.
module bcd_digit_adj
    import bcd_to_bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH) q = d - BCD_ADJ_SUB;
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter with Start/Busy/Done handshake.
// Optional BCD_RANGE_CHECK_EN rejects requests containing digits above 9 (Err with Done).
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [DIGIT_W*DIGITS-1:0] Bcd_in,
    output logic [BIN_W-1:0]          Bin_out,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Err
);

    localparam int unsigned SR_W  = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(SR_W);

    state_t state;
    state_t state_nx;

    logic [SR_W-1:0]  bcd_r;
    logic [SR_W-1:0]  bin_r;
    logic [SR_W-1:0]  bcd_sh;
    logic [SR_W-1:0]  bin_sh;
    logic [SR_W-1:0]  bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             bad_c;
    logic             load_c;
    logic             shift_c;
    logic             finish_c;

    // Combined register shifted right by one, then each BCD digit corrected.
    always_comb begin
        {bcd_sh, bin_sh} = {bcd_r, bin_r} >> 1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(bcd_sh[DIGIT_W*g +: DIGIT_W]),
            .q(bcd_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

`ifdef BCD_RANGE_CHECK_EN
    logic err_r;

    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (Bcd_in[DIGIT_W*i +: DIGIT_W] > BCD_DIGIT_MAX) bad_c = 1'b1;
        end
    end
`else
    assign bad_c = 1'b0;
    assign Err   = 1'b0;
`endif

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Start) state_nx = bad_c ? FINISH : SHIFT;
            SHIFT:   if (cnt == CNT_W'(SR_W - 1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath controls decoded from state
    always_comb begin
        load_c   = 1'b0;
        shift_c  = 1'b0;
        finish_c = 1'b0;
        case (state)
            IDLE:    load_c   = Start;
            SHIFT:   shift_c  = 1'b1;
            FINISH:  finish_c = 1'b1;
            default: ;
        endcase
    end

    // Shift register, counter and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            Bin_out <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Busy <= (state_nx == SHIFT);
            Done <= finish_c;
            if (load_c) begin
                bcd_r <= Bcd_in;
                bin_r <= '0;
                cnt   <= '0;
            end else if (shift_c) begin
                bcd_r <= bcd_adj;
                bin_r <= bin_sh;
                cnt   <= cnt + CNT_W'(1);
            end
`ifdef BCD_RANGE_CHECK_EN
            if (finish_c) Bin_out <= err_r ? '0 : bin_r[BIN_W-1:0];
`else
            if (finish_c) Bin_out <= bin_r[BIN_W-1:0];
`endif
        end
    end

`ifdef BCD_RANGE_CHECK_EN
    // Rejection flag captured at acceptance, presented with Done
    always_ff @(posedge Clock) begin
        if (Reset) begin
            err_r <= 1'b0;
            Err   <= 1'b0;
        end else begin
            if (load_c) err_r <= bad_c;
            Err <= finish_c & err_r;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases plus random BCD against a decimal model.
module tb_bcd_to_bin;

`ifdef BCD_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] Bcd_in;
    logic [13:0] Bin_out;
    logic        Busy;
    logic        Done;
    logic        Err;

    int          errors = 0;
    int          checks = 0;
    logic [13:0] hold;

    always #5 clk = ~clk;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .Clock  (clk),
        .Reset  (Reset),
        .Start  (Start),
        .Bcd_in (Bcd_in),
        .Bin_out(Bin_out),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit bcd_ok(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_val(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where Done is observed.
    task automatic do_conv(input logic [15:0] bcd, input int poke_at);
        bit ok  = bcd_ok(bcd);
        bit rej = !ok && RC;
        int lat = -1;
        int busy_n = 0;
        Start  = 1'b1;
        Bcd_in = bcd;
        @(negedge clk);
        Start  = 1'b0;
        Bcd_in = 16'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (Done) begin
                lat = k;
                break;
            end
            chk("hold", 32'(Bin_out), 32'(hold));
            if (Busy) busy_n++;
            Start  = (k == poke_at);
            Bcd_in = 16'($urandom);
        end
        Start = 1'b0;
        chk("latency", lat, rej ? 1 : 17);
        chk("busy_cycles", busy_n, rej ? 0 : 16);
        chk("err", 32'(Err), 32'(rej));
        if (ok)       chk("value", 32'(Bin_out), bcd_val(bcd));
        else if (RC)  chk("value_rej", 32'(Bin_out), 0);
        hold = ok ? 14'(bcd_val(bcd)) : (RC ? 14'd0 : Bin_out);
    endtask

    task automatic quiet(input int n);
        int extra = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (Done || Busy) extra++;
        end
        chk("quiet", extra, 0);
        chk("quiet_hold", 32'(Bin_out), 32'(hold));
    endtask

    initial begin
        logic [15:0] v;
        Reset  = 1'b1;
        Start  = 1'b0;
        Bcd_in = 16'h0000;
        hold   = '0;
        repeat (3) @(negedge clk);
        chk("rst_bin", 32'(Bin_out), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(Err), 0);
        Reset = 1'b0;
        @(negedge clk);

        do_conv(16'h0000, -1);
        @(negedge clk);
        chk("done_pulse", 32'(Done), 0);
        do_conv(16'h9999, -1);
        quiet(3);

        do_conv(16'h0042, -1);
        do_conv(16'h0059, -1);
        quiet(3);

        do_conv(16'h0321, 5);
        quiet(20);

        // Reset in the middle of a conversion
        Start  = 1'b1;
        Bcd_in = 16'h1234;
        @(negedge clk);
        Start = 1'b0;
        repeat (7) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_bin", 32'(Bin_out), 0);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_done", 32'(Done), 0);
        hold = '0;
        quiet(20);
        do_conv(16'h0777, -1);
        quiet(2);

        do_conv(16'h12A4, -1);
        quiet(2);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                v = 16'($urandom);
            end else begin
                for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            do_conv(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
            if ($urandom_range(0, 1) == 1) quiet(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
